freelist_queue_mp: RTL

FREELIST_QUEUE_MP -- requirements
Module: freelist_queue_mp

---
 rtl/freelist_queue_mp.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/freelist_queue_mp.sv
`default_nettype none
// ============================================================================
// Module  : freelist_queue_mp
// Purpose : Multi-port free-list queue. Pops up to PORTS entries from the
//           head and pushes up to PORTS entries at the tail per cycle.
//           Supports a head checkpoint (Snap/Restore/Release) so that
//           speculatively popped entries can be handed back. While a
//           checkpoint is live, pushes are limited so they can never
//           overwrite entries that a Restore would bring back.
// Ports   : Clk, Rest (async, active high)
//           RdReq/RdAck/Dout/PreOut  - pop side (Dout registered, PreOut peek)
//           WrReq/WrAck/Din          - push side
//           Clean                    - synchronous reinitialise
//           Snap/Restore/Release     - head checkpoint control
//           Count/Full/Empty/WrOvf   - status (WrOvf sticky)
// Revision: 1.0 - initial release
// ============================================================================
module freelist_queue_mp #(
  parameter int WIDTH       = 6,
  parameter int DEPTH       = 16,
  parameter int PORTS       = 2,
  parameter int INIT_BASE   = 3,
  parameter int INIT_STRIDE = 4
) (
  input  logic                     Clk,
  input  logic                     Rest,
  input  logic [PORTS-1:0]         RdReq,
  output logic                     RdAck,
  output logic [PORTS*WIDTH-1:0]   Dout,
  output logic [PORTS*WIDTH-1:0]   PreOut,
  input  logic [PORTS-1:0]         WrReq,
  input  logic [PORTS*WIDTH-1:0]   Din,
  output logic                     WrAck,
  input  logic                     Clean,
  input  logic                     Snap,
  input  logic                     Restore,
  input  logic                     Release,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty,
  output logic                     WrOvf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [PW-1:0]          r_snap_head;
  logic                   r_snap_valid;
  logic                   r_wrovf;
  logic [PORTS*WIDTH-1:0] r_dout;

  logic [1:0]             w_n;
  logic [1:0]             w_m;
  logic [PW-1:0]          w_count;
  logic [PW-1:0]          w_lim;
  logic [PW-1:0]          w_used;
  logic [PW:0]            w_need;
  logic                   w_pop;
  logic                   w_push;
  logic [AW-1:0]          w_rd_idx [PORTS];
  logic [AW-1:0]          w_wr_idx [PORTS];

  function automatic logic [WIDTH-1:0] f_init(input int i);
    return WIDTH'(INIT_BASE + i * INIT_STRIDE);
  endfunction

  always_comb begin
    w_n = '0;
    w_m = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_n = w_n + {1'b0, RdReq[p]};
      w_m = w_m + {1'b0, WrReq[p]};
    end
  end

  assign w_count = r_tail - r_head;
  // With a live checkpoint, the oldest entry that must survive is at
  // SnapHead, so free space is measured from there rather than from head.
  assign w_lim   = r_snap_valid ? r_snap_head : r_head;
  assign w_used  = r_tail - w_lim;
  assign w_need  = {1'b0, w_used} + (PW+1)'(w_m);

  assign RdAck   = (w_count >= PW'(w_n));
  assign WrAck   = (w_need <= (PW+1)'(DEPTH));
  assign w_pop   = RdAck && (w_n != 2'd0);
  assign w_push  = WrAck && (w_m != 2'd0);

  genvar gp;
  generate
    for (gp = 0; gp < PORTS; gp++) begin : g_port
      assign w_rd_idx[gp] = r_head[AW-1:0] + AW'(gp);
      assign w_wr_idx[gp] = r_tail[AW-1:0] + AW'(gp);
      assign PreOut[gp*WIDTH +: WIDTH] = r_mem[w_rd_idx[gp]];
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_head       <= '0;
      r_tail       <= PW'(DEPTH);
      r_snap_head  <= '0;
      r_snap_valid <= 1'b0;
      r_wrovf      <= 1'b0;
      r_dout       <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= f_init(i);
    end else if (Clean) begin
      r_head       <= '0;
      r_tail       <= PW'(DEPTH);
      r_snap_head  <= '0;
      r_snap_valid <= 1'b0;
      r_wrovf      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= f_init(i);
    end else begin
      // Reads use pre-edge memory, so a same-cycle push is never bypassed.
      if (w_pop) begin
        for (int p = 0; p < PORTS; p++)
          if (RdReq[p]) r_dout[p*WIDTH +: WIDTH] <= r_mem[w_rd_idx[p]];
      end

      if (w_push) begin
        for (int p = 0; p < PORTS; p++)
          if (WrReq[p]) r_mem[w_wr_idx[p]] <= Din[p*WIDTH +: WIDTH];
        r_tail <= r_tail + PW'(w_m);
      end else if (w_m != 2'd0) begin
        r_wrovf <= 1'b1;
      end

      // A valid Restore wins over the pop advance; the pop itself still
      // completes (RdAck/Dout) but its head movement is discarded.
      if (Restore && r_snap_valid) r_head <= r_snap_head;
      else if (w_pop)              r_head <= r_head + PW'(w_n);

      // Any Restore (even an ignored one) suppresses a same-cycle Snap.
      if (Restore || Release) begin
        r_snap_valid <= 1'b0;
      end else if (Snap) begin
        r_snap_head  <= r_head;
        r_snap_valid <= 1'b1;
      end
    end
  end

  assign Dout  = r_dout;
  assign Count = w_count;
  assign Full  = (w_count == PW'(DEPTH));
  assign Empty = (w_count == '0);
  assign WrOvf = r_wrovf;

endmodule
`default_nettype wire
